alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl.sv | 119 +++++++++++
 tb/tb_alu_issue_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Single-issue ALU front end: operand fetch from an 8x16 register file,
// start/handshake with an external ALU, bounded wait, and result writeback.
module alu_issue_ctrl #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [5:0]  instr_op,
   input  logic [2:0]  instr_rd,
   input  logic [2:0]  instr_rs,
   input  logic [2:0]  instr_rt,
   input  logic        instr_imm_en,
   input  logic [15:0] instr_imm,
   output logic        alu_bgn,
   output logic [5:0]  alu_opcode,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   input  logic        alu_rdy,
   input  logic [15:0] alu_acc1,
   input  logic [3:0]  alu_flags,
   output logic [3:0]  flags,
   output logic        busy,
   output logic        err_timeout,
   input  logic [2:0]  rf_raddr,
   output logic [15:0] rf_rdata
);

   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);

   localparam logic [5:0] OP_CMP = 6'd14;
   localparam logic [5:0] OP_TST = 6'd15;
   localparam logic [5:0] OP_NOP = 6'd31;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      WB    = 2'd3
   } state_t;

   state_t        state;
   logic [15:0]   rf [0:7];
   logic [TW-1:0] tcnt;
   logic [5:0]    lat_op;
   logic [2:0]    lat_rd;
   logic [15:0]   lat_res;
   logic [3:0]    lat_flags;
   logic          wr_en;

   // r0 is never written, so it reads as zero without a separate mux.
   assign wr_en = (lat_op != OP_CMP) && (lat_op != OP_TST) &&
                  (lat_op != OP_NOP) && (lat_rd != 3'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         for (int unsigned i = 0; i < 8; i++) rf[i] <= '0;
         flags       <= '0;
         alu_bgn     <= 1'b0;
         alu_opcode  <= '0;
         alu_a       <= '0;
         alu_b       <= '0;
         err_timeout <= 1'b0;
         tcnt        <= '0;
         lat_op      <= '0;
         lat_rd      <= '0;
         lat_res     <= '0;
         lat_flags   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (instr_valid) begin
                  lat_op     <= instr_op;
                  lat_rd     <= instr_rd;
                  alu_opcode <= instr_op;
                  alu_a      <= rf[instr_rs];
                  alu_b      <= instr_imm_en ? instr_imm : rf[instr_rt];
                  alu_bgn    <= 1'b1;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               alu_bgn <= 1'b0;
               tcnt    <= '0;
               state   <= WAIT;
            end
            WAIT: begin
               // A ready on the final counted cycle still wins over the abort.
               if (alu_rdy) begin
                  lat_res    <= alu_acc1;
                  lat_flags  <= alu_flags;
                  alu_opcode <= '0;
                  state      <= WB;
               end else if (tcnt == TCNT_LAST) begin
                  err_timeout <= 1'b1;
                  alu_opcode  <= '0;
                  state       <= IDLE;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            WB: begin
               if (wr_en) rf[lat_rd] <= lat_res;
               if (lat_op != OP_NOP) flags <= lat_flags;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign instr_ready = (state == IDLE);
   assign busy        = (state != IDLE);
   assign rf_rdata    = rf[rf_raddr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed scenarios plus random traffic, checked
// every cycle against a transaction-level reference model.
module tb_alu_issue_ctrl;

   localparam int TIMEOUT = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [5:0]  instr_op = '0;
   logic [2:0]  instr_rd = '0, instr_rs = '0, instr_rt = '0;
   logic        instr_imm_en = 1'b0;
   logic [15:0] instr_imm = '0;
   logic        alu_bgn;
   logic [5:0]  alu_opcode;
   logic [15:0] alu_a, alu_b;
   logic        alu_rdy = 1'b0;
   logic [15:0] alu_acc1 = '0;
   logic [3:0]  alu_flags = '0;
   logic [3:0]  flags;
   logic        busy;
   logic        err_timeout;
   logic [2:0]  rf_raddr = '0;
   logic [15:0] rf_rdata;

   always #5 clk = ~clk;

   alu_issue_ctrl #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs),
      .instr_rt(instr_rt), .instr_imm_en(instr_imm_en), .instr_imm(instr_imm),
      .alu_bgn(alu_bgn), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
      .alu_rdy(alu_rdy), .alu_acc1(alu_acc1), .alu_flags(alu_flags),
      .flags(flags), .busy(busy), .err_timeout(err_timeout),
      .rf_raddr(rf_raddr), .rf_rdata(rf_rdata)
   );

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model. m_phase: -1 no instruction, 0 start cycle, j>=1 the
   // j-th cycle spent waiting for the ALU. m_wb marks a pending writeback.
   int          m_phase;
   bit          m_wb;
   logic [15:0] m_rf [0:7];
   logic [3:0]  m_flags, m_rflg;
   logic        m_err;
   logic [5:0]  m_op;
   logic [2:0]  m_rd;
   logic [15:0] m_a, m_b, m_res;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase <= -1;
         m_wb    <= 1'b0;
         for (int i = 0; i < 8; i++) m_rf[i] <= '0;
         m_flags <= '0; m_rflg <= '0; m_err <= 1'b0;
         m_op <= '0; m_rd <= '0; m_a <= '0; m_b <= '0; m_res <= '0;
      end else if (m_wb) begin
         if (!(m_op inside {6'd14, 6'd15, 6'd31}) && m_rd != 3'd0) m_rf[m_rd] <= m_res;
         if (m_op != 6'd31) m_flags <= m_rflg;
         m_wb <= 1'b0;
      end else if (m_phase < 0) begin
         if (instr_valid) begin
            m_phase <= 0;
            m_op    <= instr_op;
            m_rd    <= instr_rd;
            m_a     <= m_rf[instr_rs];
            m_b     <= instr_imm_en ? instr_imm : m_rf[instr_rt];
         end
      end else if (m_phase == 0) begin
         m_phase <= 1;
      end else if (alu_rdy) begin
         m_res   <= alu_acc1;
         m_rflg  <= alu_flags;
         m_wb    <= 1'b1;
         m_phase <= -1;
      end else if (m_phase == TIMEOUT) begin
         m_err   <= 1'b1;
         m_phase <= -1;
      end else begin
         m_phase <= m_phase + 1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", busy, (m_phase >= 0) || m_wb);
         check("instr_ready", instr_ready, !((m_phase >= 0) || m_wb));
         check("alu_bgn", alu_bgn, m_phase == 0);
         check("alu_opcode", alu_opcode, (m_phase >= 0) ? m_op : 6'd0);
         check("alu_a", alu_a, m_a);
         check("alu_b", alu_b, m_b);
         check("flags", flags, m_flags);
         check("err_timeout", err_timeout, m_err);
         check("rf_rdata", rf_rdata, m_rf[rf_raddr]);
      end
   end

   // Stand-in ALU: returns {Z,N,C,V,result}.
   function automatic logic [19:0] alu_fn(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      logic [15:0] r;
      logic        c, v;
      s = '0; c = 1'b0; v = 1'b0;
      case (op)
         6'd1: begin
            s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16];
            v = (a[15] == b[15]) && (r[15] != a[15]);
         end
         6'd2, 6'd14: begin
            s = {1'b0, a} - {1'b0, b}; r = s[15:0]; c = s[16];
            v = (a[15] != b[15]) && (r[15] != a[15]);
         end
         6'd15:   r = a & b;
         6'd31:   return {4'hF, 16'h1234};
         default: r = a ^ b;
      endcase
      return {(r == 16'd0), r[15], c, v, r};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   // k: edge (counted from the accept edge) at which alu_rdy is seen; 0 = never.
   task automatic issue(input logic [5:0] op, input logic [2:0] rd, input logic [2:0] rs,
                        input logic [2:0] rt, input logic ie, input logic [15:0] imm, input int k);
      int n;
      n = 0;
      while (!instr_ready && n < 300) begin cyc(); n++; end
      check("ready_wait", instr_ready, 1'b1);
      rf_raddr = rd;
      instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs = rs;
      instr_rt = rt; instr_imm_en = ie; instr_imm = imm;
      cyc();
      instr_valid = 1'b0; instr_imm = 16'($urandom);
      check("bgn_first", alu_bgn, 1'b1);
      check("opcode_issue", alu_opcode, op);
      alu_rdy = 1'b1; alu_acc1 = 16'($urandom); alu_flags = 4'($urandom);
      cyc();
      check("bgn_once", alu_bgn, 1'b0);
      alu_rdy = 1'b0;
      if (k == 0) begin
         n = 0;
         while (busy && n < TIMEOUT + 10) begin cyc(); n++; end
         check("timeout_len", n, TIMEOUT);
      end else begin
         repeat (k - 2) cyc();
         {alu_flags, alu_acc1} = alu_fn(op, m_a, m_b);
         alu_rdy = 1'b1;
         cyc();
         alu_rdy = 1'b0;
         cyc();
      end
   endtask

   task automatic peek(input string name, input logic [2:0] addr, input logic [15:0] exp);
      rf_raddr = addr;
      #1;
      check(name, rf_rdata, exp);
   endtask

   initial begin
      int n;
      #1 rst_n = 1'b0;
      #1 chk_en = 1'b1;
      check("rst_busy", busy, 1'b0);
      check("rst_flags", flags, 4'h0);
      check("rst_err", err_timeout, 1'b0);
      check("rst_opcode", alu_opcode, 6'd0);
      repeat (2) cyc();
      rst_n = 1'b1;
      cyc();

      issue(6'd1, 3'd1, 3'd0, 3'd0, 1'b1, 16'd5, 2);
      peek("add_r1", 3'd1, 16'd5);
      check("add_flags", flags, 4'b0000);

      issue(6'd2, 3'd2, 3'd1, 3'd0, 1'b1, 16'd5, 3);
      peek("sub_r2", 3'd2, 16'd0);
      check("sub_flags", flags, 4'b1000);
      issue(6'd1, 3'd3, 3'd2, 3'd1, 1'b0, 16'd0, 2);
      peek("dep_r3", 3'd3, 16'd5);

      issue(6'd14, 3'd4, 3'd1, 3'd0, 1'b1, 16'd7, 2);
      peek("cmp_r4", 3'd4, 16'd0);
      check("cmp_flags", flags, 4'b0110);
      issue(6'd31, 3'd5, 3'd1, 3'd1, 1'b0, 16'd0, 4);
      peek("nop_r5", 3'd5, 16'd0);
      check("nop_flags", flags, 4'b0110);

      issue(6'd2, 3'd0, 3'd0, 3'd0, 1'b1, 16'd1, 2);
      peek("r0_zero", 3'd0, 16'd0);

      for (int c = 0; c < 500; c++) begin
         instr_valid  = ($urandom % 3) != 0;
         case ($urandom % 6)
            0: instr_op = 6'd1;  1: instr_op = 6'd2;  2: instr_op = 6'd14;
            3: instr_op = 6'd15; 4: instr_op = 6'd31; default: instr_op = 6'($urandom);
         endcase
         instr_rd = 3'($urandom); instr_rs = 3'($urandom); instr_rt = 3'($urandom);
         instr_imm_en = 1'($urandom); instr_imm = 16'($urandom);
         alu_rdy = ($urandom % 4) == 0;
         alu_acc1 = 16'($urandom); alu_flags = 4'($urandom);
         rf_raddr = 3'($urandom);
         cyc();
      end
      instr_valid = 1'b0;
      n = 0;
      while (busy && n < 100) begin alu_rdy = 1'b1; cyc(); n++; end
      alu_rdy = 1'b0;
      check("drain", busy, 1'b0);

      issue(6'd1, 3'd6, 3'd0, 3'd0, 1'b1, 16'h00A5, TIMEOUT + 1);
      peek("late_ok_r6", 3'd6, 16'h00A5);
      check("late_ok_err", err_timeout, 1'b0);

      issue(6'd1, 3'd6, 3'd0, 3'd0, 1'b1, 16'h0777, 0);
      check("to_err", err_timeout, 1'b1);
      check("to_busy", busy, 1'b0);
      peek("to_r6", 3'd6, 16'h00A5);
      issue(6'd1, 3'd7, 3'd6, 3'd0, 1'b1, 16'h0001, 3);
      peek("after_to_r7", 3'd7, 16'h00A6);
      check("err_sticky", err_timeout, 1'b1);

      // Reset in the middle of a wait, then a late ready.
      rf_raddr = 3'd3;
      instr_valid = 1'b1; instr_op = 6'd1; instr_rd = 3'd3; instr_rs = 3'd7;
      instr_imm_en = 1'b1; instr_imm = 16'd1;
      cyc();
      instr_valid = 1'b0;
      repeat (2) cyc();
      rst_n = 1'b0;
      #1;
      check("mid_busy", busy, 1'b0);
      check("mid_bgn", alu_bgn, 1'b0);
      check("mid_opcode", alu_opcode, 6'd0);
      check("mid_a", alu_a, 16'd0);
      check("mid_b", alu_b, 16'd0);
      check("mid_flags", flags, 4'h0);
      check("mid_err", err_timeout, 1'b0);
      check("mid_r3", rf_rdata, 16'd0);
      alu_rdy = 1'b1; alu_acc1 = 16'hBEEF; alu_flags = 4'hF;
      cyc();
      {alu_flags, alu_acc1} = alu_fn(6'd1, 16'd0, 16'd9);
      instr_valid = 1'b1; instr_op = 6'd1; instr_rd = 3'd2; instr_rs = 3'd0;
      instr_imm_en = 1'b1; instr_imm = 16'd9;
      #1 rst_n = 1'b1;
      cyc();
      instr_valid = 1'b0;
      check("post_rst_accept", busy, 1'b1);
      repeat (4) cyc();
      alu_rdy = 1'b0;
      check("post_rst_idle", busy, 1'b0);
      peek("post_rst_r3", 3'd3, 16'd0);
      peek("post_rst_r2", 3'd2, 16'd9);
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
